brc: RTL and testbench

Branch comparator for the RISC-V execute stage. Compares the two register-file read operands and reports equality and less-than, signed or unsigned, to the branch decision logic (BEQ/BNE/BLT/BGE/BLTU/BGEU). The primary flags are purely combinational. A one-cycle registered copy of the flags is provided for pipeline or debug use.

---
 rtl/brc.sv | 128 ++++++++++++
 tb/tb_brc.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/brc.sv
// brc -- branch comparator for the RISC-V execute stage.
//
// Compares the two register-file read operands (rs1, rs2) and reports
// equality and less-than to the branch decision logic (BEQ/BNE/BLT/BGE/
// BLTU/BGEU). The primary flags are purely combinational. A one-cycle
// registered copy of each flag is provided for pipeline/debug use.
//
// Ports:
//   i_clk          clock; drives only the registered copies and the checker
//   i_reset        synchronous, active-high reset
//   i_rs1_data     operand A (rs1), 32 bits
//   i_rs2_data     operand B (rs2), 32 bits
//   i_br_un        compare mode: 1 = signed, 0 = unsigned
//   o_br_less      combinational, A < B in the selected mode
//   o_br_equal     combinational, A == B bit for bit
//   o_br_less_q    o_br_less registered on rising i_clk (reset 0)
//   o_br_equal_q   o_br_equal registered on rising i_clk (reset 0)
//   o_chk_err      sticky self-check error (only with BRC_CHECK_EN)
//
// Build option: define BRC_CHECK_EN to add a checker that cross-checks the
// structural comparator against behavioural comparisons and raises the
// sticky o_chk_err on any disagreement.

// 4-bit magnitude comparator slice: lt = a < b, eq = a == b.
module brc_nib_cmp (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       lt,
  output logic       eq
);
  logic [3:0] e;   // per-bit equality
  logic [3:0] l;   // per-bit "a is 0 where b is 1"

  assign e = ~(a ^ b);
  assign l = ~a & b;

  // First differing bit from the MSB decides.
  assign lt = l[3]
            | (e[3] & l[2])
            | (e[3] & e[2] & l[1])
            | (e[3] & e[2] & e[1] & l[0]);
  assign eq = &e;
endmodule

module brc (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic        i_br_un,
  output logic        o_br_less,
  output logic        o_br_equal,
  output logic        o_br_less_q,
  output logic        o_br_equal_q
`ifdef BRC_CHECK_EN
  ,
  output logic        o_chk_err
`endif
);
  localparam int NUM_NIB = 8;

  // Signed mode flips both sign bits so two's complement order becomes
  // plain unsigned order; equality is unaffected since both flip together.
  logic [NUM_NIB-1:0][3:0] a_m, b_m;
  assign a_m = {i_rs1_data[31] ^ i_br_un, i_rs1_data[30:0]};
  assign b_m = {i_rs2_data[31] ^ i_br_un, i_rs2_data[30:0]};

  // Level 0: eight nibble slices.
  logic [NUM_NIB-1:0] lt_l0, eq_l0;

  for (genvar g = 0; g < NUM_NIB; g++) begin : g_nib
    brc_nib_cmp u_nib (
      .a  (a_m[g]),
      .b  (b_m[g]),
      .lt (lt_l0[g]),
      .eq (eq_l0[g])
    );
  end

  // Tree levels 1..3: odd index is the high half and takes priority.
  logic [3:0] lt_l1, eq_l1;
  logic [1:0] lt_l2, eq_l2;
  logic       lt_l3, eq_l3;

  for (genvar g = 0; g < 4; g++) begin : g_l1
    assign lt_l1[g] = lt_l0[2*g+1] | (eq_l0[2*g+1] & lt_l0[2*g]);
    assign eq_l1[g] = eq_l0[2*g+1] & eq_l0[2*g];
  end

  for (genvar g = 0; g < 2; g++) begin : g_l2
    assign lt_l2[g] = lt_l1[2*g+1] | (eq_l1[2*g+1] & lt_l1[2*g]);
    assign eq_l2[g] = eq_l1[2*g+1] & eq_l1[2*g];
  end

  assign lt_l3 = lt_l2[1] | (eq_l2[1] & lt_l2[0]);
  assign eq_l3 = eq_l2[1] & eq_l2[0];

  // Equality taken straight from the raw operands, independent of mode.
  assign o_br_equal = &(~(i_rs1_data ^ i_rs2_data));
  assign o_br_less  = lt_l3;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_br_less_q  <= 1'b0;
      o_br_equal_q <= 1'b0;
    end else begin
      o_br_less_q  <= o_br_less;
      o_br_equal_q <= o_br_equal;
    end
  end

`ifdef BRC_CHECK_EN
  logic beh_less, beh_equal, chk_mis;

  assign beh_less  = i_br_un ? ($signed(i_rs1_data) < $signed(i_rs2_data))
                             : ($unsigned(i_rs1_data) < $unsigned(i_rs2_data));
  assign beh_equal = (i_rs1_data == i_rs2_data);
  // Also catch the tree's own equality disagreeing with the direct XNOR.
  assign chk_mis   = (o_br_less != beh_less) | (o_br_equal != beh_equal)
                   | (eq_l3 != beh_equal);

  always_ff @(posedge i_clk) begin
    if (i_reset)      o_chk_err <= 1'b0;
    else if (chk_mis) o_chk_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_brc.sv
// Self-checking bench for brc: directed vectors with hand-computed results,
// registered-path/reset sequence, and a random sweep against a behavioural
// reference model.
module tb_brc;
  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_rs1_data, i_rs2_data;
  logic        i_br_un;
  logic        o_br_less, o_br_equal, o_br_less_q, o_br_equal_q;
`ifdef BRC_CHECK_EN
  logic        o_chk_err;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  brc dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rs1_data   (i_rs1_data),
    .i_rs2_data   (i_rs2_data),
    .i_br_un      (i_br_un),
    .o_br_less    (o_br_less),
    .o_br_equal   (o_br_equal),
    .o_br_less_q  (o_br_less_q),
    .o_br_equal_q (o_br_equal_q)
`ifdef BRC_CHECK_EN
    ,
    .o_chk_err    (o_chk_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Step one clock; sample 1 ns after the rising edge.
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Apply a combinational vector and check both flags.
  task automatic vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic un, input logic exp_lt, input logic exp_eq);
    i_rs1_data = a;
    i_rs2_data = b;
    i_br_un    = un;
    #1;
    chk({tag, ".less"},  {31'd0, o_br_less},  {31'd0, exp_lt});
    chk({tag, ".equal"}, {31'd0, o_br_equal}, {31'd0, exp_eq});
  endtask

  initial begin
    logic [31:0] a, b;
    logic        un, m_lt, m_eq;

    i_reset    = 1'b1;
    i_rs1_data = 32'd1;
    i_rs2_data = 32'd2;
    i_br_un    = 1'b0;

    // Reset held 2 cycles; comb path still live, registered copies cleared.
    tick;
    tick;
    chk("rst.less_q",  {31'd0, o_br_less_q},  32'd0);
    chk("rst.equal_q", {31'd0, o_br_equal_q}, 32'd0);
    chk("rst.comb_less", {31'd0, o_br_less}, 32'd1);

    // Signed mode.
    vec("s.m2002_m4000",     -32'sd2002,     -32'sd4000, 1'b1, 1'b0, 1'b0);
    vec("s.m18930002_1847",  -32'sd18930002, 32'd1847,   1'b1, 1'b1, 1'b0);
    vec("s.75830_m1000",     32'd75830,      -32'sd1000, 1'b1, 1'b0, 1'b0);
    // Unsigned mode.
    vec("u.ffff9e56_fffff060", 32'hFFFF_9E56, 32'hFFFF_F060, 1'b0, 1'b1, 1'b0);
    vec("u.75830_m2834000",    32'd75830,  -32'sd2834000,    1'b0, 1'b1, 1'b0);
    vec("u.m18930002_102847",  -32'sd18930002, 32'd102847,   1'b0, 1'b0, 1'b0);
    // Equal operands, both modes.
    vec("s.eq_pos", 32'd12500,      32'd12500,      1'b1, 1'b0, 1'b1);
    vec("u.eq_pos", 32'd12500,      32'd12500,      1'b0, 1'b0, 1'b1);
    vec("s.eq_neg", -32'sd12500,    -32'sd12500,    1'b1, 1'b0, 1'b1);
    vec("u.eq_neg", -32'sd12500,    -32'sd12500,    1'b0, 1'b0, 1'b1);
    // Sign boundaries.
    vec("s.8000_7fff", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    vec("u.8000_7fff", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0);
    vec("s.7fff_8000", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    vec("u.7fff_8000", 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    vec("s.ffff_0",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    vec("u.ffff_0",    32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    // Low-nibble-only difference exercises the full tree depth.
    vec("u.low_nib",   32'h1234_5670, 32'h1234_5671, 1'b0, 1'b1, 1'b0);

    // Registered path.
    i_reset    = 1'b0;
    i_br_un    = 1'b1;
    i_rs1_data = 32'd25002;
    i_rs2_data = 32'd4000;
    tick;
    chk("q.25002_4000.less_q",  {31'd0, o_br_less_q},  32'd0);
    chk("q.25002_4000.equal_q", {31'd0, o_br_equal_q}, 32'd0);
    i_rs1_data = 32'd125002;
    i_rs2_data = 32'd3404000;
    #1;
    chk("q.comb_less",        {31'd0, o_br_less},   32'd1);
    chk("q.less_q_lags",      {31'd0, o_br_less_q}, 32'd0);
    tick;
    chk("q.125002_3404000.less_q", {31'd0, o_br_less_q}, 32'd1);
    i_rs1_data = 32'd7;
    i_rs2_data = 32'd7;
    tick;
    chk("q.eq.equal_q", {31'd0, o_br_equal_q}, 32'd1);
    chk("q.eq.less_q",  {31'd0, o_br_less_q},  32'd0);
    // Reset mid-stream clears on the next edge.
    i_reset = 1'b1;
    tick;
    chk("q.midrst.equal_q", {31'd0, o_br_equal_q}, 32'd0);
    chk("q.midrst.less_q",  {31'd0, o_br_less_q},  32'd0);
    i_reset = 1'b0;

    // Random sweep, with every 8th vector equal and every 8th+1 MSB-differing.
    for (int i = 0; i < 10000; i++) begin
      a  = $urandom;
      b  = $urandom;
      un = 1'($urandom_range(0, 1));
      if (i % 8 == 0) b = a;
      if (i % 8 == 1) b = a ^ 32'h8000_0000;
      m_eq = (a == b);
      m_lt = un ? ($signed(a) < $signed(b)) : (a < b);
      i_rs1_data = a;
      i_rs2_data = b;
      i_br_un    = un;
      #1;
      chk("rnd.less",  {31'd0, o_br_less},  {31'd0, m_lt});
      chk("rnd.equal", {31'd0, o_br_equal}, {31'd0, m_eq});
      tick;
    end
`ifdef BRC_CHECK_EN
    chk("rnd.chk_err", {31'd0, o_chk_err}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
